// File: rtl/gl_prim_assembler.sv
// gl_prim_assembler: pops FWFT vertex/colour pairs and assembles points, lines, strips, triangles and fans for the rasterizer.
module gl_prim_assembler #(
    parameter int VERT_W  = 96,
    parameter int COLOR_W = 96,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         mode,
    input  logic               restart,
    input  logic               in_empty,
    input  logic [VERT_W-1:0]  in_vertex,
    input  logic [COLOR_W-1:0] in_color,
    output logic               in_rd_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [VERT_W-1:0]  out_v0,
    output logic [VERT_W-1:0]  out_v1,
    output logic [VERT_W-1:0]  out_v2,
    output logic [COLOR_W-1:0] out_c0,
    output logic [COLOR_W-1:0] out_c1,
    output logic [COLOR_W-1:0] out_c2,
    output logic [1:0]         out_nverts,
    output logic [CNT_W-1:0]   prim_count,
    output logic               busy
);
    // p0 holds the older vertex (or the fan pivot), p1 the most recent one
    logic [VERT_W-1:0]  pv0_q, pv1_q, pv0_d, v0_d, v1_d;
    logic [COLOR_W-1:0] pc0_q, pc1_q, pc0_d, c0_d, c1_d;
    logic [1:0]         hcnt_q, hcnt_d, nverts_d;
    logic [2:0]         mode_q, mode_in, m;
    logic               par_q, par_d, acc, emit, is_pt, is_ln, fan, flip;

    always_comb begin
        acc      = !in_empty && !restart && (!out_valid || out_ready);
        mode_in  = (mode > 3'd5) ? 3'd3 : mode;
        m        = (hcnt_q == 2'd0) ? mode_in : mode_q;
        is_pt    = m == 3'd0;
        is_ln    = (m == 3'd1) || (m == 3'd2);
        fan      = m == 3'd5;
        flip     = (m == 3'd4) && par_q;
        emit     = is_pt || (is_ln && hcnt_q != 2'd0) || hcnt_q == 2'd2;
        hcnt_d   = (is_pt || (m == 3'd1 && hcnt_q != 2'd0) || (m == 3'd3 && hcnt_q == 2'd2)) ? 2'd0 :
                   (hcnt_q == 2'd2) ? 2'd2 : hcnt_q + 2'd1;
        par_d    = par_q ^ ((m == 3'd4) && emit);
        nverts_d = is_pt ? 2'd1 : is_ln ? 2'd2 : 2'd3;
        v0_d     = is_pt ? in_vertex : (is_ln || flip) ? pv1_q : pv0_q;
        c0_d     = is_pt ? in_color : (is_ln || flip) ? pc1_q : pc0_q;
        v1_d     = (is_pt || is_ln) ? in_vertex : flip ? pv0_q : pv1_q;
        c1_d     = (is_pt || is_ln) ? in_color : flip ? pc0_q : pc1_q;
        // the fan pivot is captured once and never shifted out
        pv0_d    = fan ? ((hcnt_q != 2'd0) ? pv0_q : in_vertex) : pv1_q;
        pc0_d    = fan ? ((hcnt_q != 2'd0) ? pc0_q : in_color) : pc1_q;
        in_rd_en = acc;
        busy     = out_valid || hcnt_q != 2'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q     <= '0;
            par_q      <= 1'b0;
            mode_q     <= '0;
            pv0_q      <= '0;
            pv1_q      <= '0;
            pc0_q      <= '0;
            pc1_q      <= '0;
            out_valid  <= 1'b0;
            out_v0     <= '0;
            out_v1     <= '0;
            out_v2     <= '0;
            out_c0     <= '0;
            out_c1     <= '0;
            out_c2     <= '0;
            out_nverts <= '0;
            prim_count <= '0;
        end else begin
            if (restart) begin
                hcnt_q <= '0;
                par_q  <= 1'b0;
                mode_q <= mode_in;
            end else if (acc) begin
                hcnt_q <= hcnt_d;
                par_q  <= par_d;
                mode_q <= m;
                pv0_q  <= pv0_d;
                pc0_q  <= pc0_d;
                pv1_q  <= in_vertex;
                pc1_q  <= in_color;
            end
            if (acc && emit) begin
                out_valid  <= 1'b1;
                out_v0     <= v0_d;
                out_v1     <= v1_d;
                out_v2     <= in_vertex;
                out_c0     <= c0_d;
                out_c1     <= c1_d;
                out_c2     <= in_color;
                out_nverts <= nverts_d;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready)
                prim_count <= prim_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_gl_prim_assembler.sv
// tb_gl_prim_assembler: directed and random stimulus against a vertex-list reference model of primitive assembly.
module tb_gl_prim_assembler;
    typedef logic [95:0] w_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] mode = '0;
    logic       restart = 1'b0, in_empty = 1'b1, out_ready = 1'b0;
    w_t         in_vertex = '0, in_color = '0;
    logic       in_rd_en, out_valid, busy;
    w_t         out_v0, out_v1, out_v2, out_c0, out_c1, out_c2;
    logic [1:0] out_nverts;
    logic [3:0] prim_count;

    gl_prim_assembler #(.VERT_W(96), .COLOR_W(96), .CNT_W(4)) dut (
        .clk(clk), .reset(rst), .mode(mode), .restart(restart), .in_empty(in_empty),
        .in_vertex(in_vertex), .in_color(in_color), .in_rd_en(in_rd_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_v0(out_v0), .out_v1(out_v1), .out_v2(out_v2),
        .out_c0(out_c0), .out_c1(out_c1), .out_c2(out_c2),
        .out_nverts(out_nverts), .prim_count(prim_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0, errors = 0;
    w_t vq[$], cq[$], lv[$], lc[$];
    w_t m_v[3], m_c[3];
    logic [1:0] m_n;
    logic [3:0] m_cnt;
    bit   m_valid, emit;
    int   lmode;

    function automatic w_t rnd();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        lv.delete(); lc.delete();
        lmode = 0; m_valid = 0; m_n = '0; m_cnt = '0;
        for (int i = 0; i < 3; i++) begin m_v[i] = '0; m_c[i] = '0; end
    endtask

    task automatic put(input int a, input int b, input int c, input logic [1:0] nv);
        m_v[0] = lv[a]; m_v[1] = lv[b]; m_v[2] = lv[c];
        m_c[0] = lc[a]; m_c[1] = lc[b]; m_c[2] = lc[c];
        m_n = nv; emit = 1;
    endtask

    task automatic check_all(input bit erd);
        chk("in_rd_en", in_rd_en, erd);
        chk("out_valid", out_valid, m_valid);
        chk("prim_count", prim_count, m_cnt);
        chk("busy", busy, m_valid || lv.size() != 0);
        if (m_valid) begin
            chk("nverts", out_nverts, m_n);
            chk("v0", out_v0, m_v[0]); chk("v1", out_v1, m_v[1]); chk("v2", out_v2, m_v[2]);
            chk("c0", out_c0, m_c[0]); chk("c1", out_c1, m_c[1]); chk("c2", out_c2, m_c[2]);
        end
    endtask

    task automatic push();
        vq.push_back(rnd()); cq.push_back(rnd());
    endtask

    task automatic cyc(input bit rs, input logic [2:0] md, input bit rdy, input bit hold);
        bit erd, hs;
        int n;
        @(negedge clk);
        restart = rs; mode = md; out_ready = rdy;
        in_empty = hold || vq.size() == 0;
        in_vertex = vq.size() != 0 ? vq[0] : rnd();
        in_color  = cq.size() != 0 ? cq[0] : rnd();
        #1;
        erd = !in_empty && !rs && (!m_valid || rdy);
        check_all(erd);
        hs = m_valid && rdy;
        if (hs) m_cnt++;
        emit = 0;
        if (rs) begin
            lv.delete(); lc.delete();
            lmode = md > 5 ? 3 : int'(md);
        end else if (erd) begin
            if (lv.size() == 0) lmode = md > 5 ? 3 : int'(md);
            lv.push_back(vq.pop_front()); lc.push_back(cq.pop_front());
            n = lv.size() - 1;
            if (lmode == 0) begin put(n, n, n, 1); lv.delete(); lc.delete(); end
            else if (lmode == 1) begin
                if (n % 2 == 1) begin put(n-1, n, n, 2); lv.delete(); lc.delete(); end
            end else if (lmode == 2) begin
                if (n >= 1) put(n-1, n, n, 2);
            end else if (lmode == 3) begin
                if (n == 2) begin put(0, 1, 2, 3); lv.delete(); lc.delete(); end
            end else if (lmode == 4) begin
                if (n >= 2) begin
                    if ((n - 2) % 2 == 0) put(n-2, n-1, n, 3);
                    else put(n-1, n-2, n, 3);
                end
            end else if (n >= 2) put(0, n-1, n, 3);
        end
        if (emit) m_valid = 1;
        else if (hs) m_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; in_empty = 1; restart = 0; out_ready = 0;
        vq.delete(); cq.delete();
        model_reset();
        #1;
        check_all(0);
        chk("rst_v0", out_v0, 0);
        chk("rst_nverts", out_nverts, 0);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 3'd0, rdy, 0);
    endtask

    initial begin
        model_reset();
        do_reset();
        // independent triangles, back-to-back
        cyc(1, 3'd3, 1, 0);
        for (int i = 0; i < 6; i++) push();
        for (int i = 0; i < 8; i++) cyc(0, 3'd3, 1, 0);
        idle(2, 1);
        chk("tri_count", prim_count, 2);
        // triangle strip, then restart mid-strip
        cyc(1, 3'd4, 1, 0);
        for (int i = 0; i < 5; i++) push();
        for (int i = 0; i < 7; i++) cyc(0, 3'd4, 1, 0);
        cyc(1, 3'd4, 1, 0);
        for (int i = 0; i < 3; i++) push();
        for (int i = 0; i < 5; i++) cyc(0, 3'd4, 1, 0);
        // triangle fan with back-pressure after the first triangle
        cyc(1, 3'd5, 1, 0);
        for (int i = 0; i < 4; i++) push();
        for (int i = 0; i < 4; i++) cyc(0, 3'd5, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 3'd5, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 3'd5, 1, 0);
        // mode change mid-line is ignored until the line completes
        cyc(1, 3'd1, 1, 0);
        push(); cyc(0, 3'd1, 1, 0);
        push(); cyc(0, 3'd0, 1, 0);
        push(); cyc(0, 3'd0, 1, 0);
        idle(2, 1);
        // line strip and mode 6 aliasing to triangles
        cyc(1, 3'd2, 1, 0);
        for (int i = 0; i < 4; i++) push();
        for (int i = 0; i < 6; i++) cyc(0, 3'd2, 1, 0);
        cyc(1, 3'd6, 1, 0);
        for (int i = 0; i < 3; i++) push();
        for (int i = 0; i < 5; i++) cyc(0, 3'd7, 1, 0);
        // random traffic: modes, restarts, empties, back-pressure
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0 && vq.size() < 4) push();
            cyc($urandom_range(0, 24) == 0, 3'($urandom_range(0, 7)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
        end
        idle(3, 1);
        // reset while a fan triangle is presented and history is full
        cyc(1, 3'd5, 1, 0);
        for (int i = 0; i < 3; i++) push();
        for (int i = 0; i < 4; i++) cyc(0, 3'd5, 0, 0);
        chk("pre_rst_valid", out_valid, 1);
        do_reset();
        cyc(0, 3'd0, 1, 1);
        // counter wrap with a 4-bit counter
        for (int i = 0; i < 17; i++) push();
        for (int i = 0; i < 20; i++) cyc(0, 3'd0, 1, 0);
        chk("wrap_count", prim_count, 1);
        chk("wrap_busy", busy, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
